// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers. The functions take a 32-bit container plus the live width n,
// so a single package serves every instance width.
package johnson_pkg;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} jstate_t;

  // Code for state index k: thermometer fill for 0..n, then the ones drain out from the bottom.
  function automatic logic [31:0] jc_code(input int k, input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    if (k <= n) return (32'd1 << k) - 32'd1;
    return mask & ~((32'd1 << (k - n)) - 32'd1);
  endfunction

  function automatic logic jc_is_legal(input logic [31:0] code, input int n);
    for (int k = 0; k < 2 * n; k++)
      if (code == jc_code(k, n)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int jc_to_idx(input logic [31:0] code, input int n);
    for (int k = 0; k < 2 * n; k++)
      if (code == jc_code(k, n)) return k;
    return 0;
  endfunction

  function automatic logic [31:0] jc_next(input logic [31:0] code, input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return ((code << 1) | {31'd0, ~code[n-1]}) & mask;
  endfunction
endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code classifier: legality, state index and one-hot.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]   code,
  output logic           legal,
  output logic [IW-1:0]  idx,
  output logic [2*N-1:0] onehot
);
  always_comb begin
    legal  = jc_is_legal(32'(code), N);
    idx    = IW'(jc_to_idx(32'(code), N));
    onehot = '0;
    if (legal) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/johnson_decoder.sv
// Johnson bus decoder and sequence monitor: registered index/one-hot, legality and
// step checking, lock FSM and a saturating error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            code_in,
  input  logic                    code_valid,
  output logic                    valid_out,
  output logic [$clog2(2*N)-1:0]  idx,
  output logic [2*N-1:0]          onehot,
  output logic                    illegal_code,
  output logic                    seq_error,
  output logic                    wrap,
  output logic                    locked,
  output logic [ERR_W-1:0]        err_count
);
  localparam int S  = 2 * N;
  localparam int IW = $clog2(S);
  localparam logic [IW-1:0] LAST = IW'(S - 1);
  localparam logic [3:0]    LC   = 4'(LOCK_CNT);

  logic          c_legal;
  logic [IW-1:0] c_idx;
  logic [S-1:0]  c_oh;

  johnson_code_check #(.N(N), .IW(IW)) u_chk (
    .code   (code_in),
    .legal  (c_legal),
    .idx    (c_idx),
    .onehot (c_oh)
  );

  jstate_t       state;
  logic [3:0]    run;
  logic [IW-1:0] prev;
  logic          have_prev;

  logic [IW-1:0] succ;
  logic          step, hold;
  logic [3:0]    run_nxt;

  always_comb begin
    succ    = (prev == LAST) ? '0 : prev + 1'b1;
    step    = have_prev & c_legal & (c_idx == succ);
    hold    = have_prev & c_legal & (c_idx == prev) & (ALLOW_HOLD != 0);
    run_nxt = 4'd1;
    if (step)      run_nxt = (run >= LC) ? LC : run + 4'd1;
    else if (hold) run_nxt = run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      idx          <= '0;
      onehot       <= '0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      wrap         <= 1'b0;
      locked       <= 1'b0;
      err_count    <= '0;
      state        <= UNLOCKED;
      run          <= '0;
      prev         <= '0;
      have_prev    <= 1'b0;
    end else begin
      valid_out    <= code_valid;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      wrap         <= 1'b0;
      if (code_valid) begin
        idx    <= c_idx;
        onehot <= c_oh;
        case (state)
          UNLOCKED: begin
            if (!c_legal) begin
              illegal_code <= 1'b1;
              run          <= '0;
              have_prev    <= 1'b0;
            end else begin
              run       <= run_nxt;
              prev      <= c_idx;
              have_prev <= 1'b1;
              if (run_nxt >= LC) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (!c_legal) begin
              illegal_code <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              state     <= UNLOCKED;
              locked    <= 1'b0;
              run       <= '0;
              have_prev <= 1'b0;
            end else if (step) begin
              wrap <= (prev == LAST) && (c_idx == '0);
              prev <= c_idx;
            end else if (!hold) begin
              // out of step: flag it, then trust the new sample as the reference
              seq_error <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              prev <= c_idx;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// Directed and randomized checks of johnson_decoder against a behavioural model.
module tb_johnson_decoder;
  import johnson_pkg::*;

  localparam int N = 4, S = 8, LOCK = 3;

  logic       clk = 1'b0, rst = 1'b0, code_valid = 1'b0;
  logic [3:0] code_in = '0;
  logic       valid_out, illegal_code, seq_error, wrap, locked;
  logic [2:0] idx;
  logic [7:0] onehot, err_count;

  johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ERR_W(8), .ALLOW_HOLD(0)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .valid_out(valid_out), .idx(idx), .onehot(onehot), .illegal_code(illegal_code),
    .seq_error(seq_error), .wrap(wrap), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // model state
  logic       e_vo, e_ill, e_seq, e_wrap, e_locked;
  logic [2:0] e_idx;
  logic [7:0] e_oh, e_err;
  int         m_run, m_prev;
  bit         m_hp;

  function automatic int m_find(input logic [3:0] c);
    logic [31:0] x;
    x = 32'd0;
    for (int k = 0; k < S; k++) begin
      if (x[3:0] == c) return k;
      x = jc_next(x, N);
    end
    return -1;
  endfunction

  function automatic logic [23:0] got_v();
    return {valid_out, idx, onehot, illegal_code, seq_error, wrap, locked, err_count};
  endfunction

  function automatic logic [23:0] exp_v();
    return {e_vo, e_idx, e_oh, e_ill, e_seq, e_wrap, e_locked, e_err};
  endfunction

  task automatic m_reset();
    e_vo = 0; e_ill = 0; e_seq = 0; e_wrap = 0; e_locked = 0;
    e_idx = 0; e_oh = 0; e_err = 0; m_run = 0; m_prev = 0; m_hp = 0;
  endtask

  task automatic bump_err();
    if (e_err != 8'hFF) e_err = e_err + 8'd1;
  endtask

  task automatic m_sample(input logic [3:0] c);
    int  k;
    bit  in_step;
    k = m_find(c);
    e_vo = 1;
    e_idx = (k >= 0) ? 3'(k) : 3'd0;
    e_oh  = (k >= 0) ? 8'(1 << k) : 8'd0;
    in_step = m_hp && (k >= 0) && (k == (m_prev + 1) % S);
    if (!e_locked) begin
      if (k < 0) begin
        e_ill = 1; m_run = 0; m_hp = 0;
      end else begin
        m_run = in_step ? ((m_run + 1 > LOCK) ? LOCK : m_run + 1) : 1;
        m_hp = 1; m_prev = k;
        if (m_run >= LOCK) e_locked = 1;
      end
    end else begin
      if (k < 0) begin
        e_ill = 1; bump_err(); e_locked = 0; m_run = 0; m_hp = 0;
      end else if (in_step) begin
        e_wrap = (m_prev == S - 1) && (k == 0);
        m_prev = k;
      end else begin
        e_seq = 1; bump_err(); m_prev = k;
      end
    end
  endtask

  // Drive one cycle, advance the model, then settle before the caller samples.
  task automatic step(input logic r, input logic [3:0] c, input logic v);
    @(negedge clk);
    rst = r; code_in = c; code_valid = v;
    @(posedge clk);
    if (r) m_reset();
    else begin
      e_vo = 0; e_ill = 0; e_seq = 0; e_wrap = 0;
      if (v) m_sample(c);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 4'h0, 1'b0);
    n_tests++;
    if (got_v() !== 24'h0) begin
      n_fail++; $display("FAIL reset got=%h exp=%h", got_v(), 24'h0);
    end
    step(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_clean_seq();
    logic [31:0] c;
    c = 32'd0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, c[3:0], 1'b1);
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; $display("FAIL clean[%0d] got=%h exp=%h", i, got_v(), exp_v());
      end
      if (i == 2 || i == 3) begin
        n_tests++;
        if (locked !== (i == 3)) begin
          n_fail++; $display("FAIL lock_rise[%0d] got=%b exp=%b", i, locked, (i == 3));
        end
      end
      if (i == 9) begin
        n_tests++;
        if ({wrap, idx, onehot, err_count} !== {1'b1, 3'd0, 8'h01, 8'd0}) begin
          n_fail++; $display("FAIL wrap got=%b/%0d/%h/%0d exp=1/0/01/0", wrap, idx, onehot, err_count);
        end
      end
      c = jc_next(c, N);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] seq [3];
    seq = '{4'b0001, 4'b0011, 4'b0111};
    step(1'b0, 4'b0101, 1'b1);
    n_tests++;
    if ({illegal_code, onehot, err_count, locked} !== {1'b1, 8'h00, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL illegal got=%b/%h/%0d/%b exp=1/00/1/0", illegal_code, onehot, err_count, locked);
    end
    foreach (seq[i]) begin
      step(1'b0, seq[i], 1'b1);
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; $display("FAIL relock[%0d] got=%h exp=%h", i, got_v(), exp_v());
      end
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL relock_level got=%b exp=1", locked);
    end
  endtask

  task automatic test_seq_error();
    logic [3:0] seq [7];
    seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011};
    foreach (seq[i]) step(1'b0, seq[i], 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    n_tests++;
    if ({seq_error, err_count, locked, idx} !== {1'b1, 8'd2, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL seq_err got=%b/%0d/%b/%0d exp=1/2/1/4", seq_error, err_count, locked, idx);
    end
    step(1'b0, 4'b1110, 1'b1);
    n_tests++;
    if ({seq_error, illegal_code, err_count, idx} !== {1'b0, 1'b0, 8'd2, 3'd5}) begin
      n_fail++; $display("FAIL seq_resume got=%b/%b/%0d/%0d exp=0/0/2/5", seq_error, illegal_code, err_count, idx);
    end
  endtask

  task automatic test_valid_gap();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      n_tests++;
      if (got_v() !== exp_v() || {valid_out, idx, locked} !== {1'b0, 3'd5, 1'b1}) begin
        n_fail++; $display("FAIL gap[%0d] got=%h exp=%h", i, got_v(), exp_v());
      end
    end
    step(1'b0, 4'b1100, 1'b1);
    n_tests++;
    if ({valid_out, seq_error, idx} !== {1'b1, 1'b0, 3'd6}) begin
      n_fail++; $display("FAIL gap_resume got=%b/%b/%0d exp=1/0/6", valid_out, seq_error, idx);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 1'b1);
    n_tests++;
    if ({err_count, locked} !== {8'd5, 1'b1}) begin
      n_fail++; $display("FAIL pre_rst got=%0d/%b exp=5/1", err_count, locked);
    end
    step(1'b1, 4'b0000, 1'b1);
    n_tests++;
    if (got_v() !== 24'h0) begin
      n_fail++; $display("FAIL mid_rst got=%h exp=%h", got_v(), 24'h0);
    end
    step(1'b0, 4'b0111, 1'b1);
    n_tests++;
    if ({valid_out, idx, seq_error, locked, err_count} !== {1'b1, 3'd3, 1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL post_rst_seed got=%h exp=%h", got_v(), exp_v());
    end
  endtask

  task automatic test_saturation();
    int bad;
    logic [7:0] last;
    bad = 0; last = 0;
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0011, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, (i % 2 == 0) ? 4'b0000 : 4'b1111, 1'b1);
      if (got_v() !== exp_v() || err_count < last) bad++;
      last = err_count;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL sat_stream got=%0d bad cycles exp=0", bad);
    end
    n_tests++;
    if ({err_count, locked} !== {8'd255, 1'b1}) begin
      n_fail++; $display("FAIL sat_value got=%0d/%b exp=255/1", err_count, locked);
    end
  endtask

  task automatic test_random();
    logic [31:0] c;
    logic [3:0]  d;
    int bad;
    bad = 0;
    c = 32'd0;
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) d = c[3:0];
      else d = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 149) == 0), d, ($urandom_range(0, 7) != 0));
      if (code_valid) c = jc_next({28'd0, d}, N);
      n_tests++;
      if (got_v() !== exp_v()) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL random[%0d] got=%h exp=%h", i, got_v(), exp_v());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_clean_seq();
    test_illegal();
    test_seq_error();
    test_valid_gap();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
